// File: rtl/block_output_pkg.sv
// Shared router definitions: port indices, default widths and the round-robin
// successor helper used by the output-port arbiter.
package block_output_pkg;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_N_PORT     = 5;

    // Port that gets top priority after port idx has been served.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/block_output_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
// The pointer moves past the winner only when a grant is actually issued.
module rr_arbiter
    import block_output_pkg::*;
#(
    parameter int N_PORT = DEFAULT_N_PORT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PORT-1:0] req,
    input  logic              enable,
    output logic [N_PORT-1:0] grant
);

    localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win;
    logic          found;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        // Grant is held off during reset as well as when the FIFO is full.
        if (enable && rst) begin
            for (int k = 0; k < N_PORT; k++) begin
                idx = (int'(rr_ptr) + k) % N_PORT;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    win        = PW'(idx);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= PW'(rr_next(int'(win), N_PORT));
        end
    end

endmodule

// File: rtl/block_output.sv
// Output-port block: round-robin arbitration into a small FIFO, drained to the
// neighbour router with a val/ret handshake.
module block_output
    import block_output_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N_PORT     = DEFAULT_N_PORT,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORT-1:0]            req,
    input  logic [N_PORT*DATA_WIDTH-1:0] Data_in,
    output logic [N_PORT-1:0]            grant,
    output logic                         val,
    input  logic                         ret,
    output logic [DATA_WIDTH-1:0]        Data_out,
    output logic                         full,
    output logic                         empty
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push;
    logic                  pop;

    rr_arbiter #(.N_PORT(N_PORT)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .enable (~full),
        .grant  (grant)
    );

    // The grant is one-hot or zero, so OR-ing the gated slices selects the winner.
    always_comb begin
        push_data = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (grant[i]) push_data = push_data | Data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign push     = |grant;
    assign pop      = val & ret;
    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign val      = ~empty;
    assign Data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared in reset so Data_out reads zero and no stale flit survives a reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_block_output.sv
// Self-checking bench for block_output: table-driven vectors with a flit
// scoreboard, plus hand-written reset and pointer-wrap sequences.
module tb_block_output;

    localparam int DW = 8;
    localparam int NP = 5;
    localparam int FD = 4;

    typedef struct {
        logic [NP-1:0]    req;
        logic [NP*DW-1:0] data;
        logic             ret;
        logic [NP-1:0]    exp_grant;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req;
    logic [NP*DW-1:0] Data_in;
    logic [NP-1:0]    grant;
    logic             val;
    logic             ret;
    logic [DW-1:0]    Data_out;
    logic             full;
    logic             empty;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_q[$];
    vec_t          vecs[$];

    block_output #(.DATA_WIDTH(DW), .N_PORT(NP), .FIFO_DEPTH(FD), .PTR_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .Data_in  (Data_in),
        .grant    (grant),
        .val      (val),
        .ret      (ret),
        .Data_out (Data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NP-1:0] r, input logic [NP*DW-1:0] d,
                                input logic rt, input logic [NP-1:0] g);
        vec_t v;
        v.req = r; v.data = d; v.ret = rt; v.exp_grant = g;
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] one_slice(input int port, input logic [DW-1:0] b);
        logic [NP*DW-1:0] d;
        d = '0;
        d[port*DW +: DW] = b;
        return d;
    endfunction

    // Drive one cycle, compare mid-cycle, then update the scoreboard for the coming edge.
    task automatic step(input vec_t v, input string name);
        req = v.req; Data_in = v.data; ret = v.ret;
        @(negedge clk);
        check({name, ".grant"}, 64'(grant), 64'(v.exp_grant));
        check({name, ".val"},   64'(val),   64'(sb_q.size() != 0));
        check({name, ".full"},  64'(full),  64'(sb_q.size() == FD));
        check({name, ".empty"}, 64'(empty), 64'(sb_q.size() == 0));
        if (sb_q.size() != 0) begin
            check({name, ".data"}, 64'(Data_out), 64'(sb_q[0]));
            if (v.ret) void'(sb_q.pop_front());
        end
        for (int i = 0; i < NP; i++)
            if (v.exp_grant[i]) sb_q.push_back(v.data[i*DW +: DW]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NP*DW-1:0] d;

        // Round-robin from reset: every port requests for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            d = '0;
            for (int i = 0; i < NP; i++) d[i*DW +: DW] = DW'((k << 4) | i);
            vecs.push_back(mk(5'b11111, d, 1'b1, NP'(1 << (k % NP))));
        end
        vecs.push_back(mk('0, '0, 1'b1, '0));
        vecs.push_back(mk('0, '0, 1'b1, '0));
        // Single flit from port 2.
        vecs.push_back(mk(5'b00100, one_slice(2, 8'hA5), 1'b1, 5'b00100));
        vecs.push_back(mk('0, '0, 1'b1, '0));
        vecs.push_back(mk('0, '0, 1'b1, '0));
        // Pointer skip: rr_ptr=3, only port 0 requests; afterwards port 1 must win over port 0.
        vecs.push_back(mk(5'b00001, one_slice(0, 8'h3C), 1'b1, 5'b00001));
        vecs.push_back(mk(5'b00011, one_slice(0, 8'h11) | one_slice(1, 8'h22), 1'b1, 5'b00010));
        vecs.push_back(mk('0, '0, 1'b1, '0));
        vecs.push_back(mk('0, '0, 1'b1, '0));
        // Backpressure: four grants fill the FIFO, flit 5 waits until a pop frees a slot.
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(5'b00010, one_slice(1, DW'(k)), 1'b0, 5'b00010));
        vecs.push_back(mk(5'b00010, one_slice(1, 8'd5), 1'b0, '0));
        vecs.push_back(mk(5'b00010, one_slice(1, 8'd5), 1'b0, '0));
        vecs.push_back(mk(5'b00010, one_slice(1, 8'd5), 1'b1, '0));
        vecs.push_back(mk(5'b00010, one_slice(1, 8'd5), 1'b1, 5'b00010));
        for (int k = 0; k < 4; k++) vecs.push_back(mk('0, '0, 1'b1, '0));

        rst = 1'b0; req = '0; Data_in = '0; ret = 1'b0;
        @(negedge clk);
        check("reset.val",   64'(val),      64'(0));
        check("reset.empty", 64'(empty),    64'(1));
        check("reset.full",  64'(full),     64'(0));
        check("reset.grant", 64'(grant),    64'(0));
        check("reset.data",  64'(Data_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        for (int n = 0; n < vecs.size(); n++) step(vecs[n], $sformatf("vec%0d", n));

        // Pointer wrap: hold two flits queued, then push and pop together for 12 cycles.
        step(mk(5'b01000, one_slice(3, 8'h80), 1'b0, 5'b01000), "wrap_fill0");
        step(mk(5'b01000, one_slice(3, 8'h81), 1'b0, 5'b01000), "wrap_fill1");
        for (int k = 2; k < 14; k++)
            step(mk(5'b01000, one_slice(3, DW'(8'h80 + k)), 1'b1, 5'b01000),
                 $sformatf("wrap%0d", k));
        for (int k = 0; k < 3; k++) step(mk('0, '0, 1'b1, '0), "wrap_drain");

        // Asynchronous reset with three flits queued and a request still pending.
        for (int k = 0; k < 3; k++)
            step(mk(5'b00001, one_slice(0, DW'(8'hC0 + k)), 1'b0, 5'b00001), "rst_fill");
        req = 5'b00001; Data_in = one_slice(0, 8'hC3); ret = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst.val",   64'(val),      64'(0));
        check("midrst.empty", 64'(empty),    64'(1));
        check("midrst.full",  64'(full),     64'(0));
        check("midrst.grant", 64'(grant),    64'(0));
        check("midrst.data",  64'(Data_out), 64'(0));
        sb_q.delete();
        req = '0; ret = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) step(mk('0, '0, 1'b1, '0), "post_rst_idle");
        step(mk(5'b10000, one_slice(4, 8'h5A), 1'b1, 5'b10000), "post_rst_flit");
        step(mk('0, '0, 1'b1, '0), "post_rst_drain");
        step(mk('0, '0, 1'b1, '0), "post_rst_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
